// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants and types for the multicycle MIPS control FSM
//               and the downstream ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RWB     = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_ILLEGAL = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_dbg;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Combinational map from FSM state (plus mem_ready, rst_n) to
//               every datapath control output.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  input  logic       rst_n_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.state_dbg = state_i;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR load and PC+4 commit only on the cycle memory delivers the word
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl_o.illegal_op = 1'b1;
      end
      default: begin
        ctrl_o.illegal_op = 1'b0;
      end
    endcase

    // Side-effecting strobes are suppressed while reset is held; selects keep decoding.
    if (!rst_n_i) begin
      ctrl_o.pc_write      = 1'b0;
      ctrl_o.pc_write_cond = 1'b0;
      ctrl_o.ir_write      = 1'b0;
      ctrl_o.mem_read      = 1'b0;
      ctrl_o.mem_write     = 1'b0;
      ctrl_o.reg_write     = 1'b0;
      ctrl_o.instr_done    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Multicycle MIPS main control FSM: state register and
//               next-state logic; outputs come from mc_ctrl_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUop,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_ILLEGAL;
        endcase
      end
      // Opcode is looked at again here to split load from store.
      ST_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = ST_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_ILLEGAL;
        end
      end
      ST_MEMRD:   if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_MEMWR:   if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:    state_d = ST_RWB;
      ST_RWB:     state_d = ST_FETCH;
      ST_BRANCH:  state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      ST_ADDIWB:  state_d = ST_FETCH;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_ILLEGAL;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .rst_n_i     (rst_n),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign ALUop         = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = ctrl.state_dbg;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_control
// Description : Self-checking bench for mc_main_control with an
//               instruction-path reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, ALUop, pc_source;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  int m_state = 0;
  bit m_valid = 1'b0;
  int plan[$];

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUop(ALUop),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [21:0] pack_dut();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, ALUop, pc_source, instr_done,
            illegal_op, state_dbg};
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic logic [21:0] expect_out(input int s, input logic mr, input logic rn);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0;
    logic sa = 0, dn = 0, il = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (s)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mwr = 1; io = 1; dn = mr; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      9:  begin pw = 1; ps = 2'b10; dn = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      12: il = 1;
      default: il = 0;
    endcase
    if (!rn) begin
      pw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; dn = 0;
    end
    return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, dn, il, 4'(s)};
  endfunction

  // States an instruction walks through after DECODE.
  task automatic load_plan(input logic [5:0] op);
    plan.delete();
    case (op)
      6'b000000: begin plan.push_back(6);  plan.push_back(7); end
      6'b100011: begin plan.push_back(2);  plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2);  plan.push_back(5); end
      6'b000100: plan.push_back(8);
      6'b000010: plan.push_back(9);
      6'b001000: begin plan.push_back(10); plan.push_back(11); end
      default:   plan.push_back(12);
    endcase
  endtask

  // Compare process plus model advance at each clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) check("outputs", 32'(pack_dut()), 32'(expect_out(m_state, mem_ready, rst_n)));
      @(posedge clk);
      if (!rst_n) begin
        m_state = 0;
        plan.delete();
        m_valid = 1'b1;
      end else if (m_valid) begin
        case (m_state)
          0:  if (mem_ready) m_state = 1;
          1:  begin load_plan(opcode); m_state = plan.pop_front(); end
          12: m_state = 12;
          default: begin
            if ((m_state == 3 || m_state == 5) && !mem_ready) m_state = m_state;
            else if (plan.size() > 0) m_state = plan.pop_front();
            else m_state = 0;
          end
        endcase
      end
    end
  end

  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int exp_cycles, input string name);
    int cyc = 0;
    int fs = 0;
    int ms = 0;
    bit done = 1'b0;
    opcode = op;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (state_dbg == 4'd0 && fs < fstall) begin
        mem_ready = 1'b0; fs++;
      end else if ((state_dbg == 4'd3 || state_dbg == 4'd5) && ms < mstall) begin
        mem_ready = 1'b0; ms++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      if (instr_done) done = 1'b1;
    end
    check(name, 32'(cyc), 32'(exp_cycles));
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    int r = $urandom_range(0, 13);
    if (r < 12) return legal[r % 6];
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset state_dbg", 32'(state_dbg), 0);
    check("reset mem_read", 32'(mem_read), 1);
    check("reset alu_src_b", 32'(alu_src_b), 1);
    check("reset ir_write", 32'(ir_write), 0);
    check("reset pc_write", 32'(pc_write), 0);

    run_instr(6'b000000, 0, 0, 4, "R cycles");
    check("R reg_write", 32'(reg_write), 1);
    check("R reg_dst", 32'(reg_dst), 1);
    run_instr(6'b100011, 2, 3, 10, "lw stalled cycles");
    check("lw mem_to_reg", 32'(mem_to_reg), 1);
    run_instr(6'b101011, 0, 0, 4, "sw cycles");
    check("sw mem_write", 32'(mem_write), 1);
    run_instr(6'b000100, 0, 0, 3, "beq cycles");
    check("beq ALUop", 32'(ALUop), 1);
    check("beq pc_write_cond", 32'(pc_write_cond), 1);
    check("beq pc_source", 32'(pc_source), 1);
    run_instr(6'b000010, 0, 0, 3, "j cycles");
    check("j pc_write", 32'(pc_write), 1);
    check("j pc_source", 32'(pc_source), 2);
    run_instr(6'b001000, 0, 0, 4, "addi cycles");
    check("addi reg_dst", 32'(reg_dst), 0);
    run_instr(6'b100011, 0, 0, 5, "lw cycles");

    // Illegal opcode trap
    opcode = 6'b111111;
    n = 0;
    do begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      n++;
    end while (state_dbg != 4'd12 && n < 10);
    check("illegal entered", 32'(state_dbg), 12);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (illegal_op && state_dbg == 4'd12) n++;
    end
    check("illegal held cycles", 32'(n), 20);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("illegal reset state", 32'(state_dbg), 0);
    check("illegal reset flag", 32'(illegal_op), 0);

    // Reset in the middle of a stalled store
    opcode = 6'b101011;
    n = 0;
    do begin
      @(negedge clk);
      mem_ready = (state_dbg == 4'd5) ? 1'b0 : 1'b1;
      #1;
      n++;
    end while (state_dbg != 4'd5 && n < 10);
    check("sw reached MEMWR", 32'(state_dbg), 5);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset MEMWR mem_write", 32'(mem_write), 0);
    check("reset MEMWR instr_done", 32'(instr_done), 0);
    check("reset MEMWR state", 32'(state_dbg), 5);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after reset state", 32'(state_dbg), 0);
    check("after reset instr_done", 32'(instr_done), 0);

    // Random instruction stream against the model
    repeat (3000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 59) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      if (m_state == 0) opcode = pick_op();
    end

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
